// File: rtl/heap_pkg.sv
// Shared types and constants for the heap arbiter: FSM states, requester indices, default widths.
package heap_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 12;

   localparam logic EXECUTOR = 1'b0;
   localparam logic LOADER   = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } heap_state_e;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/heap_arb_rr.sv
// Two-way round-robin pick: the requester that did not win last time is preferred when valid.
module heap_arb_rr
   import heap_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic       winner
);

   always_comb begin
      winner = last;
      if (valid[~last]) winner = ~last;
   end

endmodule

// File: rtl/heap_arbiter.sv
// Two-requester arbiter in front of a single-port heap memory, one access per three cycles.
// Optional per-requester grant counters are built when HEAP_ARBITER_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; grants and captures the command on the same cycle
// ISSUE | presents the captured command to the memory for one cycle
// RESP  | returns read data (or the written data) to the winner
module heap_arbiter
   import heap_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_in,
   input  logic [DATA_WIDTH-1:0]   mem_out,
   output logic                    busy
`ifdef HEAP_ARBITER_STATS_EN
   ,
   output logic [31:0]             grant_count
`endif
);

   heap_state_e           state_q, state_d;
   logic                  last_q, last_d;
   logic                  win_q, win_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pick;
   logic                  grant;

   heap_arb_rr u_rr (
      .valid  (req_valid),
      .last   (last_q),
      .winner (pick)
   );

   assign grant = (state_q == IDLE) && (|req_valid);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      req_ready = 2'b00;
      case (state_q)
         IDLE: begin
            if (grant) begin
               req_ready = onehot2(pick);
               win_d     = pick;
               last_d    = pick;
               wr_d      = req_write[pick];
               addr_d    = (pick == LOADER) ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                            : req_addr[ADDR_WIDTH-1:0];
               data_d    = (pick == LOADER) ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : req_wdata[DATA_WIDTH-1:0];
               state_d   = ISSUE;
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory drive and response are decoded from state so an async reset drops them at once.
   always_comb begin
      mem_write   = 1'b0;
      mem_address = '0;
      mem_in      = '0;
      rsp_valid   = 2'b00;
      rsp_data    = '0;
      busy        = 1'b0;
      case (state_q)
         ISSUE: begin
            mem_write   = wr_q;
            mem_address = addr_q;
            mem_in      = data_q;
            busy        = 1'b1;
         end
         RESP: begin
            rsp_valid = onehot2(win_q);
            rsp_data  = wr_q ? data_q : mem_out;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= LOADER;
         win_q   <= EXECUTOR;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

`ifdef HEAP_ARBITER_STATS_EN
   logic [1:0][15:0] gcnt_q, gcnt_d;

   always_comb begin
      gcnt_d = gcnt_q;
      if (grant && (gcnt_q[pick] != 16'hFFFF)) gcnt_d[pick] = gcnt_q[pick] + 16'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) gcnt_q <= '0;
      else        gcnt_q <= gcnt_d;
   end

   assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_heap_arbiter.sv
// Self-checking bench for heap_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model (round-robin rule, shadow memory, grant counters under HEAP_ARBITER_STATS_EN).
module tb_heap_arbiter;
   import heap_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_write = '0;
   logic [23:0] req_addr = '0;
   logic [23:0] req_wdata = '0;
   logic [1:0]  rsp_valid;
   logic [11:0] rsp_data;
   logic        mem_write;
   logic [11:0] mem_address;
   logic [11:0] mem_in;
   logic [11:0] mem_out = '0;
   logic        busy;
`ifdef HEAP_ARBITER_STATS_EN
   logic [31:0] grant_count;
`endif

   heap_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_in      (mem_in),
      .mem_out     (mem_out),
      .busy        (busy)
`ifdef HEAP_ARBITER_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   always #5 clock = ~clock;

   // Heap memory: one-cycle read latency, read-before-write.
   logic [11:0] mem [0:4095];
   always @(posedge clock) begin
      if (mem_write) mem[mem_address] <= mem_in;
      mem_out <= mem[mem_address];
   end

   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] shadow [0:4095];
   logic        last_m;
   int          cnt_m [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic model_pick(input logic [1:0] v);
      if (v[!last_m]) return !last_m;
      return last_m;
   endfunction

   function automatic logic [1:0] oh(input logic i);
      return i ? 2'b10 : 2'b01;
   endfunction

   task automatic model_reset();
      last_m = 1'b1;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
   endtask

   task automatic set_req(input int r, input logic w, input logic [11:0] a, input logic [11:0] d);
      req_valid[r] = 1'b1;
      req_write[r] = w;
      req_addr[r*12 +: 12] = a;
      req_wdata[r*12 +: 12] = d;
   endtask

   // One arbitration round starting in IDLE with inputs already driven (time = posedge + 1).
   task automatic run_round(input bit drop_other);
      logic        w, wr;
      logic [11:0] a, d, exp_d;
      #1;
      if (req_valid == 2'b00) begin
         chk("idle_ready", req_ready, 2'b00);
         chk("idle_busy", busy, 1'b0);
         @(posedge clock); #1;
         return;
      end
      w  = model_pick(req_valid);
      wr = req_write[w];
      a  = req_addr[w*12 +: 12];
      d  = req_wdata[w*12 +: 12];
      chk("grant_ready", req_ready, oh(w));
      chk("grant_busy", busy, 1'b0);
      @(posedge clock); #1;
      req_valid[w] = 1'b0;
      if (drop_other) req_valid[!w] = 1'b0;
      chk("issue_we", mem_write, wr);
      chk("issue_addr", mem_address, a);
      if (wr) chk("issue_din", mem_in, d);
      chk("issue_busy", busy, 1'b1);
      chk("issue_ready", req_ready, 2'b00);
      exp_d = wr ? d : shadow[a];
      if (wr) shadow[a] = d;
      last_m = w;
      if (cnt_m[w] < 65535) cnt_m[w]++;
      @(posedge clock); #1;
      chk("resp_valid", rsp_valid, oh(w));
      chk("resp_data", rsp_data, exp_d);
      chk("resp_we", mem_write, 1'b0);
      chk("resp_ready", req_ready, 2'b00);
      @(posedge clock); #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      req_valid = 2'b00;
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      model_reset();
      #12;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_rsp", rsp_valid, 2'b00);
      chk("rst_we", mem_write, 1'b0);
      chk("rst_addr", mem_address, 12'h0);
      chk("rst_din", mem_in, 12'h0);
      chk("rst_rdata", rsp_data, 12'h0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Write then read-back through the other requester.
      set_req(0, 1'b1, 12'd5, 12'h0AB);
      run_round(1'b0);
      set_req(1, 1'b0, 12'd5, 12'h000);
      run_round(1'b0);

      // Both requesters held valid: 0,1,0,1 after reset; then a lone request from 0.
      pulse_reset();
      for (int g = 0; g < 4; g++) begin
         set_req(0, 1'b0, 12'(g), 12'h0);
         set_req(1, 1'b0, 12'(g + 8), 12'h0);
         run_round(1'b0);
         chk("rr_order", last_m, (g % 2 == 1) ? 1'b1 : 1'b0);
         req_valid = 2'b00;
      end
      set_req(0, 1'b1, 12'd7, 12'h777);
      run_round(1'b0);
`ifdef HEAP_ARBITER_STATS_EN
      chk("stats_23", grant_count, 32'h0002_0003);
`endif

      // Requester 1 cancels while requester 0 is served.
      set_req(1, 1'b1, 12'd3, 12'h333);
      run_round(1'b0);
      set_req(0, 1'b0, 12'd5, 12'h0);
      set_req(1, 1'b1, 12'd6, 12'h666);
      run_round(1'b1);
      for (int c = 0; c < 3; c++) begin
         chk("cancel_ready", req_ready, 2'b00);
         chk("cancel_we", mem_write, 1'b0);
         @(posedge clock); #1;
      end
      chk("cancel_nowrite", mem[6], shadow[6]);

      // Reset during ISSUE aborts the write without retry.
      set_req(0, 1'b1, 12'd9, 12'h123);
      #1;
      chk("abort_ready", req_ready, 2'b01);
      @(posedge clock); #1;
      chk("abort_issue_we", mem_write, 1'b1);
      reset = 1'b0;
      req_valid = 2'b00;
      model_reset();
      #1;
      chk("abort_we", mem_write, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rsp", rsp_valid, 2'b00);
      chk("abort_addr", mem_address, 12'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk("abort_norsp", rsp_valid, 2'b00);
         chk("abort_nobusy", busy, 1'b0);
         @(posedge clock); #1;
      end
      set_req(1, 1'b0, 12'd9, 12'h0);
      run_round(1'b0);

      // Randomized rounds; a waiting loser keeps its command until granted or cancelled.
      for (int t = 0; t < 300; t++) begin
         for (int r = 0; r < 2; r++) begin
            if (!req_valid[r] && ($urandom_range(0, 2) != 0))
               set_req(r, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                       12'($urandom_range(0, 4095)));
         end
         run_round($urandom_range(0, 3) == 0);
      end
      req_valid = 2'b00;
      @(posedge clock); #1;
`ifdef HEAP_ARBITER_STATS_EN
      chk("stats_final", grant_count, {16'(cnt_m[1]), 16'(cnt_m[0])});
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
